icache_line_fill: RTL and testbench

Line-fill engine between the L1 instruction cache and `MainMemory` instruction port 1. On an L1 miss it fetches the eight words of the missing line one at a time over the `MEM_RDEN1`/`MEM_ADDR1`/`memValid1` handshake. It assembles the words into a line buffer and presents the complete line to the L1 with a one-cycle `LINE_VALID` pulse.

---
 rtl/icache_line_fill.sv | 158 +++++++++++++++
 tb/tb_icache_line_fill.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// ============================================================================
// icache_line_fill
//
// Line-fill engine between the L1 instruction cache and memory port 1.
// On an L1 miss it fetches the WORDS_PER_LINE words of the missing line one
// at a time over the MEM_RDEN1 / MEM_ADDR1 / memValid1 handshake. It assembles
// them into a line buffer and announces the finished line with a one-cycle
// LINE_VALID pulse.
//
// Optional feature macro: ICACHE_CWF_EN (critical word first). When it is
// defined, the fill starts at the missed word and wraps around the line, and
// the missed word is presented early on CRIT_VALID / CRIT_DATA. When it is
// undefined, the fill runs 0..WORDS_PER_LINE-1 and the CRIT_* outputs are
// tied to 0.
//
// Ports:
//   MEM_CLK     in   clock, rising edge
//   RST         in   asynchronous active-high reset
//   MISS        in   L1 miss request (level, held until LINE_VALID)
//   MISS_ADDR   in   word address of the missing instruction
//   MEM_RDEN1   out  read enable to memory port 1
//   MEM_ADDR1   out  word address to memory port 1 (0 outside REQ)
//   MEM_DOUT1   in   word returned by memory
//   memValid1   in   MEM_DOUT1 valid for the current MEM_ADDR1
//   BUSY        out  fill in progress
//   LINE_ADDR   out  line index of the filled line
//   LINE_DATA   out  assembled line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   LINE_VALID  out  one-cycle pulse: line complete
//   CRIT_VALID  out  one-cycle pulse: missed word available
//   CRIT_DATA   out  missed word
// ============================================================================
module icache_line_fill #(
  parameter  int WORDS_PER_LINE = 8,
  parameter  int ADDR_WIDTH     = 14,
  parameter  int DATA_WIDTH     = 32,
  localparam int OFF_BITS       = $clog2(WORDS_PER_LINE)
) (
  input  logic                                MEM_CLK,
  input  logic                                RST,
  input  logic                                MISS,
  input  logic [ADDR_WIDTH-1:0]               MISS_ADDR,
  output logic                                MEM_RDEN1,
  output logic [ADDR_WIDTH-1:0]               MEM_ADDR1,
  input  logic [DATA_WIDTH-1:0]               MEM_DOUT1,
  input  logic                                memValid1,
  output logic                                BUSY,
  output logic [ADDR_WIDTH-OFF_BITS-1:0]      LINE_ADDR,
  output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] LINE_DATA,
  output logic                                LINE_VALID,
  output logic                                CRIT_VALID,
  output logic [DATA_WIDTH-1:0]               CRIT_DATA
);

  localparam logic [OFF_BITS-1:0] LAST_COUNT = OFF_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t              state;
  logic [OFF_BITS-1:0] offset;
  logic [OFF_BITS-1:0] count;
  logic [OFF_BITS-1:0] start_off;
  logic [DATA_WIDTH-1:0] buffer [WORDS_PER_LINE];

`ifdef ICACHE_CWF_EN
  assign start_off = MISS_ADDR[OFF_BITS-1:0];
`else
  // Line always fetched from word 0; the in-line offset of the miss is unused.
  logic unused_miss_off;
  assign unused_miss_off = ^MISS_ADDR[OFF_BITS-1:0];
  assign start_off       = '0;
`endif

  // The buffer doubles as the line output; words are overwritten in place as
  // the next fill proceeds.
  for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_pack
    assign LINE_DATA[i*DATA_WIDTH +: DATA_WIDTH] = buffer[i];
  end

  // Control FSM. All outputs are registered here, so memValid1 never reaches
  // an output combinationally.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      BUSY       <= 1'b0;
      MEM_RDEN1  <= 1'b0;
      MEM_ADDR1  <= '0;
      LINE_VALID <= 1'b0;
      LINE_ADDR  <= '0;
      offset     <= '0;
      count      <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MISS) begin
            state     <= REQ;
            BUSY      <= 1'b1;
            MEM_RDEN1 <= 1'b1;
            MEM_ADDR1 <= {MISS_ADDR[ADDR_WIDTH-1:OFF_BITS], start_off};
            LINE_ADDR <= MISS_ADDR[ADDR_WIDTH-1:OFF_BITS];
            offset    <= start_off;
            count     <= '0;
          end
        end
        REQ: begin
          if (memValid1) begin
            buffer[offset] <= MEM_DOUT1;
            offset         <= offset + 1'b1;  // wraps around the line
            count          <= count + 1'b1;
            MEM_RDEN1      <= 1'b0;
            MEM_ADDR1      <= '0;
            if (count == LAST_COUNT) begin
              state      <= DONE;
              LINE_VALID <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          // One idle cycle with the read enable low so the memory restarts
          // its latency for the next address.
          state     <= REQ;
          MEM_RDEN1 <= 1'b1;
          MEM_ADDR1 <= {LINE_ADDR, offset};
        end
        DONE: begin
          // MISS is deliberately not sampled here; a held MISS is taken in
          // IDLE on the next edge.
          state      <= IDLE;
          BUSY       <= 1'b0;
          LINE_VALID <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_CWF_EN
  // The first capture of a fill is always the missed word.
  logic first_capture;
  assign first_capture = (state == REQ) && memValid1 && (count == '0);

  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      CRIT_VALID <= 1'b0;
      CRIT_DATA  <= '0;
    end else begin
      CRIT_VALID <= first_capture;
      if (first_capture) CRIT_DATA <= MEM_DOUT1;
    end
  end
`else
  assign CRIT_VALID = 1'b0;
  assign CRIT_DATA  = '0;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// ============================================================================
// tb_icache_line_fill
//
// Self-checking bench for icache_line_fill (default parameters). A behavioural
// memory answers each request after k cycles with word(a) = 0xA000_0000 | a.
// Expected fetch order, line contents and latencies are computed from the
// line-fill rules with plain arithmetic. Builds with or without ICACHE_CWF_EN.
// ============================================================================
module tb_icache_line_fill;

  localparam int WPL = 8;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int OB  = 3;

  logic                 MEM_CLK = 1'b0;
  logic                 RST;
  logic                 MISS;
  logic [AW-1:0]        MISS_ADDR;
  logic                 MEM_RDEN1;
  logic [AW-1:0]        MEM_ADDR1;
  logic [DW-1:0]        MEM_DOUT1;
  logic                 memValid1;
  logic                 BUSY;
  logic [AW-OB-1:0]     LINE_ADDR;
  logic [WPL*DW-1:0]    LINE_DATA;
  logic                 LINE_VALID;
  logic                 CRIT_VALID;
  logic [DW-1:0]        CRIT_DATA;

  icache_line_fill #(.WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .MEM_CLK   (MEM_CLK),
    .RST       (RST),
    .MISS      (MISS),
    .MISS_ADDR (MISS_ADDR),
    .MEM_RDEN1 (MEM_RDEN1),
    .MEM_ADDR1 (MEM_ADDR1),
    .MEM_DOUT1 (MEM_DOUT1),
    .memValid1 (memValid1),
    .BUSY      (BUSY),
    .LINE_ADDR (LINE_ADDR),
    .LINE_DATA (LINE_DATA),
    .LINE_VALID(LINE_VALID),
    .CRIT_VALID(CRIT_VALID),
    .CRIT_DATA (CRIT_DATA)
  );

  always #5 MEM_CLK = ~MEM_CLK;

  int checks = 0;
  int errors = 0;

  // Observation / memory-model state
  int            cyc = 0;
  int            nvalid, ncrit, nreq, lv_cyc, crit_cyc, ksum, kfirst, kcfg, wait_left;
  bit            in_req, prev_rden, force_valid;
  logic [DW-1:0] crit_seen;
  logic [WPL*DW-1:0] snap_data;
  logic [AW-OB-1:0]  snap_laddr;
  logic [AW-1:0]     cap_q[$];

  typedef struct {
    logic [AW-1:0]    addr;
    int               k;
    logic [AW-OB-1:0] exp_laddr;
    int               exp_lat;
  } vec_t;

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return 32'hA000_0000 | {18'd0, a};
  endfunction

  function automatic logic [WPL*DW-1:0] line_of(input logic [AW-1:0] a);
    logic [WPL*DW-1:0] l;
    logic [AW-1:0]     base;
    base = a & ~14'd7;
    for (int i = 0; i < WPL; i++) l[i*DW +: DW] = word_of(base + 14'(i));
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    nvalid = 0; ncrit = 0; nreq = 0; lv_cyc = -1; crit_cyc = -1;
    ksum = 0; kfirst = -1; crit_seen = '0;
    cap_q.delete();
  endtask

  // One cycle: observe outputs at the falling edge, then drive the memory.
  task automatic tick();
    @(negedge MEM_CLK);
    cyc++;
    if (LINE_VALID) begin
      nvalid++;
      if (lv_cyc < 0) begin
        lv_cyc = cyc; snap_data = LINE_DATA; snap_laddr = LINE_ADDR;
      end
    end
    if (CRIT_VALID) begin
      ncrit++; crit_cyc = cyc; crit_seen = CRIT_DATA;
    end
    if (MEM_RDEN1 && !prev_rden) nreq++;
    prev_rden = MEM_RDEN1;
    if (MEM_RDEN1) begin
      if (!in_req) begin
        in_req    = 1'b1;
        wait_left = (kcfg < 0) ? int'($urandom_range(0, 3)) : kcfg;
        ksum     += wait_left;
        if (kfirst < 0) kfirst = wait_left;
      end
      if (wait_left == 0) begin
        memValid1 = 1'b1;
        MEM_DOUT1 = word_of(MEM_ADDR1);
        cap_q.push_back(MEM_ADDR1);
        in_req    = 1'b0;
      end else begin
        memValid1 = 1'b0;
        MEM_DOUT1 = '0;
        wait_left--;
      end
    end else begin
      in_req    = 1'b0;
      memValid1 = force_valid;
      MEM_DOUT1 = force_valid ? 32'hDEAD_BEEF : 32'h0;
    end
  endtask

  // Checks fetch order and critical-word behaviour for a fill started at t0.
  task automatic check_order_crit(input logic [AW-1:0] addr, input int t0, input string tag);
    int start;
    logic [AW-1:0] base;
    base  = addr & ~14'd7;
`ifdef ICACHE_CWF_EN
    start = int'(addr[2:0]);
`else
    start = 0;
`endif
    chk({tag, "_nreq"}, 256'(nreq), 256'd8);
    chk({tag, "_ncap"}, 256'(cap_q.size()), 256'd8);
    for (int i = 0; i < WPL && i < cap_q.size(); i++)
      chk({tag, "_addr"}, 256'(cap_q[i]), 256'(base | 14'((start + i) % WPL)));
`ifdef ICACHE_CWF_EN
    chk({tag, "_ncrit"}, 256'(ncrit), 256'd1);
    chk({tag, "_crit_cyc"}, 256'(crit_cyc - t0), 256'(kfirst + 2));
    chk({tag, "_crit_data"}, 256'(crit_seen), 256'(word_of(addr)));
`else
    chk({tag, "_ncrit"}, 256'(ncrit), 256'd0);
    chk({tag, "_crit_data"}, 256'(CRIT_DATA), 256'd0);
`endif
  endtask

  // Full fill; latency returned as LINE_VALID cycle minus MISS-sample cycle.
  task automatic do_fill(input logic [AW-1:0] addr, input int kmode, input bit frc,
                         input string tag, output int lat, output logic [AW-OB-1:0] laddr);
    int t0;
    force_valid = frc;
    kcfg        = kmode;
    if (frc) begin tick(); tick(); end
    clear_obs();
    MISS = 1'b1; MISS_ADDR = addr; t0 = cyc;
    for (int n = 0; n < 300 && lv_cyc < 0; n++) tick();
    MISS = 1'b0;
    if (lv_cyc < 0) begin
      chk({tag, "_timeout"}, 256'd1, 256'd0);
      lat = -1; laddr = '0;
    end else begin
      lat = lv_cyc - t0; laddr = snap_laddr;
      chk({tag, "_lat_rule"}, 256'(lat), 256'(16 + ksum));
      chk({tag, "_line_data"}, snap_data, line_of(addr));
      check_order_crit(addr, t0, tag);
    end
    tick();
    chk({tag, "_busy_after"}, 256'(BUSY), 256'd0);
    chk({tag, "_one_pulse"}, 256'(nvalid), 256'd1);
    force_valid = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    int lat, t0, t1;
    logic [AW-OB-1:0] la;

    vecs[0] = '{14'h0000, 3, 11'h000, 40};
    vecs[1] = '{14'h3FFD, 0, 11'h7FF, 16};
    vecs[2] = '{14'h1234, 1, 11'h246, 24};
    vecs[3] = '{14'h0007, 2, 11'h000, 32};

    RST = 1'b1; MISS = 1'b0; MISS_ADDR = '0; MEM_DOUT1 = '0; memValid1 = 1'b0;
    force_valid = 1'b0; kcfg = 0; in_req = 1'b0; prev_rden = 1'b0; wait_left = 0;
    clear_obs();
    repeat (3) tick();
    chk("rst_busy", 256'(BUSY), 256'd0);
    chk("rst_rden", 256'(MEM_RDEN1), 256'd0);
    chk("rst_maddr", 256'(MEM_ADDR1), 256'd0);
    chk("rst_lvalid", 256'(LINE_VALID), 256'd0);
    chk("rst_laddr", 256'(LINE_ADDR), 256'd0);
    chk("rst_ldata", LINE_DATA, 256'd0);
    chk("rst_crit", 256'({CRIT_VALID, CRIT_DATA}), 256'd0);
    RST = 1'b0;
    tick();

    // Table-driven fills
    for (int v = 0; v < 4; v++) begin
      do_fill(vecs[v].addr, vecs[v].k, 1'b0, $sformatf("vec%0d", v), lat, la);
      chk($sformatf("vec%0d_lat", v), 256'(lat), 256'(vecs[v].exp_lat));
      chk($sformatf("vec%0d_laddr", v), 256'(la), 256'(vecs[v].exp_laddr));
    end

    // memValid1 forced high outside REQ (idle and gap cycles)
    do_fill(14'h0100, 0, 1'b1, "force", lat, la);
    chk("force_lat", 256'(lat), 256'd16);
    chk("force_laddr", 256'(la), 256'h020);

    // MISS held through two fills, MISS_ADDR changed mid-fill
    kcfg = 0; clear_obs();
    MISS = 1'b1; MISS_ADDR = 14'h0000; t0 = cyc;
    for (int n = 0; n < 100 && lv_cyc < 0; n++) begin
      tick();
      if (n == 5) MISS_ADDR = 14'h0010;
    end
    chk("two_a_lat", 256'(lv_cyc - t0), 256'd16);
    chk("two_a_laddr", 256'(snap_laddr), 256'h000);
    chk("two_a_data", snap_data, line_of(14'h0000));
    tick();
    chk("two_idle_busy", 256'(BUSY), 256'd0);
    t1 = cyc;
    clear_obs();
    for (int n = 0; n < 100 && lv_cyc < 0; n++) tick();
    MISS = 1'b0;
    chk("two_b_lat", 256'(lv_cyc - t1), 256'd16);
    chk("two_b_laddr", 256'(snap_laddr), 256'h002);
    chk("two_b_data", snap_data, line_of(14'h0010));
    tick(); tick();

    // Asynchronous reset after the 4th capture
    kcfg = 1; clear_obs();
    MISS = 1'b1; MISS_ADDR = 14'h0020;
    for (int n = 0; n < 100 && cap_q.size() < 4; n++) tick();
    tick();
    chk("rst_mid_caps", 256'(cap_q.size()), 256'd4);
    MISS = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("amid_busy", 256'(BUSY), 256'd0);
    chk("amid_rden", 256'(MEM_RDEN1), 256'd0);
    chk("amid_maddr", 256'(MEM_ADDR1), 256'd0);
    chk("amid_laddr", 256'(LINE_ADDR), 256'd0);
    chk("amid_ldata", LINE_DATA, 256'd0);
    chk("amid_crit", 256'({CRIT_VALID, CRIT_DATA}), 256'd0);
    in_req = 1'b0;
    tick(); tick();
    RST = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    chk("amid_no_lvalid", 256'(nvalid), 256'd0);
    chk("amid_idle", 256'(BUSY), 256'd0);
    do_fill(14'h0008, 0, 1'b0, "after_rst", lat, la);
    chk("after_rst_lat", 256'(lat), 256'd16);
    chk("after_rst_laddr", 256'(la), 256'h001);

    // Randomized fills against the arithmetic model
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] ra;
      ra = AW'($urandom_range(0, 16383));
      do_fill(ra, -1, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r), lat, la);
      chk($sformatf("rnd%0d_laddr", r), 256'(la), 256'(ra >> 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
